// File: rtl/rom2ram_multi.sv
// rom2ram_multi: power-up copier moving up to REGIONS flash byte ranges
// into SRAM, with optional read-back verify and bounded retry.
//
// Ports:
//   clk28, rst           clock, synchronous active-high reset
//   start                one-cycle start pulse (ignored while busy)
//   region_en/rom/ram/len  packed per-region descriptors
//   rom_req/addr/ack/data  flash byte reader handshake
//   ram_wren/rden/addr/dout/din/grant  SRAM access handshake
//   busy, done, error    copy status (done/error sticky)
//   err_region, err_addr location of the byte that failed verify

module rom2ram_multi #(
   parameter int unsigned ROM_AW     = 24,
   parameter int unsigned RAM_AW     = 19,
   parameter int unsigned LEN_W      = 17,
   parameter int unsigned REGIONS    = 4,
   parameter logic [31:0] ROM_OFFSET = 32'h0001_3256,
   parameter bit          VERIFY     = 1'b1,
   parameter int unsigned RETRIES    = 2,
   parameter bit          AUTO_START = 1'b1,
   localparam int unsigned EW = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
   input  logic                       clk28,
   input  logic                       rst,
   input  logic                       start,
   input  logic [REGIONS-1:0]         region_en,
   input  logic [REGIONS*ROM_AW-1:0]  region_rom,
   input  logic [REGIONS*RAM_AW-1:0]  region_ram,
   input  logic [REGIONS*LEN_W-1:0]   region_len,
   output logic                       rom_req,
   output logic [ROM_AW-1:0]          rom_addr,
   input  logic                       rom_ack,
   input  logic [7:0]                 rom_data,
   output logic                       ram_wren,
   output logic                       ram_rden,
   output logic [RAM_AW-1:0]          ram_addr,
   output logic [7:0]                 ram_dout,
   input  logic [7:0]                 ram_din,
   input  logic                       ram_grant,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [EW-1:0]              err_region,
   output logic [RAM_AW-1:0]          err_addr
);

   localparam int unsigned CW = $clog2(REGIONS + 1);
   localparam int unsigned RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
   localparam logic [ROM_AW-1:0] OFF = ROM_AW'(ROM_OFFSET);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_ROM_REQ, S_RAM_WR,
      S_RAM_RD, S_NEXT, S_DONE, S_ERROR
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CW-1:0]       r_idx;
   logic [ROM_AW-1:0]   r_src;
   logic [RAM_AW-1:0]   r_dst;
   logic [LEN_W-1:0]    r_cnt;
   logic [7:0]          r_byte;
   logic [RW-1:0]       r_retry;
   logic                r_auto;
   logic [EW-1:0]       r_err_region;
   logic [RAM_AW-1:0]   r_err_addr;

   logic                w_en;
   logic [ROM_AW-1:0]   w_rom;
   logic [RAM_AW-1:0]   w_ram;
   logic [LEN_W-1:0]    w_len;
   logic                w_last;
   logic                w_skip;
   logic                w_start;
   logic                w_match;
   logic                w_retry_ok;

   // Descriptor for the current index; r_idx==REGIONS selects nothing.
   always_comb begin
      w_en  = 1'b0;
      w_rom = '0;
      w_ram = '0;
      w_len = '0;
      for (int i = 0; i < REGIONS; i++) begin
         if (r_idx == CW'(i)) begin
            w_en  = region_en[i];
            w_rom = region_rom[i*ROM_AW +: ROM_AW];
            w_ram = region_ram[i*RAM_AW +: RAM_AW];
            w_len = region_len[i*LEN_W +: LEN_W];
         end
      end
   end

   assign w_last     = (r_idx == CW'(REGIONS));
   assign w_skip     = !w_en || (w_len == '0);
   // r_auto is high only on the first cycle after reset release.
   assign w_start    = start || r_auto;
   assign w_match    = (ram_din == r_byte);
   assign w_retry_ok = (r_retry < RW'(RETRIES));

   always_ff @(posedge clk28) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_DONE, S_ERROR:
            if (w_start) w_next = S_SELECT;
         S_SELECT:
            if (w_last)       w_next = S_DONE;
            else if (!w_skip) w_next = S_ROM_REQ;
         S_ROM_REQ:
            if (rom_ack) w_next = S_RAM_WR;
         S_RAM_WR:
            if (ram_grant) w_next = VERIFY ? S_RAM_RD : S_NEXT;
         S_RAM_RD:
            if (ram_grant) begin
               if (w_match)         w_next = S_NEXT;
               else if (w_retry_ok) w_next = S_RAM_WR;
               else                 w_next = S_ERROR;
            end
         S_NEXT:
            w_next = (r_cnt == LEN_W'(1)) ? S_SELECT : S_ROM_REQ;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         r_idx        <= '0;
         r_src        <= '0;
         r_dst        <= '0;
         r_cnt        <= '0;
         r_byte       <= '0;
         r_retry      <= '0;
         r_auto       <= AUTO_START;
         r_err_region <= '0;
         r_err_addr   <= '0;
      end else begin
         r_auto <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR:
               if (w_start) begin
                  r_idx        <= '0;
                  r_retry      <= '0;
                  r_err_region <= '0;
                  r_err_addr   <= '0;
               end
            S_SELECT:
               if (!w_last) begin
                  if (w_skip) begin
                     r_idx <= r_idx + CW'(1);
                  end else begin
                     r_src   <= w_rom + OFF;
                     r_dst   <= w_ram;
                     r_cnt   <= w_len;
                     r_retry <= '0;
                  end
               end
            S_ROM_REQ:
               if (rom_ack) r_byte <= rom_data;
            S_RAM_RD:
               if (ram_grant) begin
                  if (w_match) begin
                     r_retry <= '0;
                  end else if (w_retry_ok) begin
                     r_retry <= r_retry + RW'(1);
                  end else begin
                     r_err_region <= EW'(r_idx);
                     r_err_addr   <= r_dst;
                  end
               end
            S_NEXT: begin
               r_src <= r_src + ROM_AW'(1);
               r_dst <= r_dst + RAM_AW'(1);
               r_cnt <= r_cnt - LEN_W'(1);
               if (r_cnt == LEN_W'(1)) r_idx <= r_idx + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Requests decode from a single state, so they are mutually exclusive.
   always_comb begin
      rom_req    = (r_state == S_ROM_REQ);
      ram_wren   = (r_state == S_RAM_WR);
      ram_rden   = (r_state == S_RAM_RD);
      busy       = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
      done       = (r_state == S_DONE);
      error      = (r_state == S_ERROR);
      rom_addr   = r_src;
      ram_addr   = r_dst;
      ram_dout   = r_byte;
      err_region = r_err_region;
      err_addr   = r_err_addr;
   end

endmodule

// File: tb/tb_rom2ram_multi.sv
// tb_rom2ram_multi: scoreboard bench for rom2ram_multi with flash and
// SRAM models, stall/corruption injection and a reference copy model.

module tb_rom2ram_multi;

   localparam int ROM_AW  = 24;
   localparam int RAM_AW  = 19;
   localparam int LEN_W   = 17;
   localparam int REGIONS = 2;
   localparam int RETRIES = 2;
   localparam int OFF     = 'h013256;

   logic clk28 = 1'b0;
   always #5 clk28 = ~clk28;

   logic                      rst = 1'b1;
   logic                      start = 1'b0;
   logic [REGIONS-1:0]        region_en = '0;
   logic [REGIONS*ROM_AW-1:0] region_rom = '0;
   logic [REGIONS*RAM_AW-1:0] region_ram = '0;
   logic [REGIONS*LEN_W-1:0]  region_len = '0;
   logic                      rom_req;
   logic [ROM_AW-1:0]         rom_addr;
   logic                      rom_ack = 1'b0;
   logic [7:0]                rom_data = '0;
   logic                      ram_wren, ram_rden;
   logic [RAM_AW-1:0]         ram_addr;
   logic [7:0]                ram_dout;
   logic [7:0]                ram_din = '0;
   logic                      ram_grant = 1'b0;
   logic                      busy, done, error;
   logic [0:0]                err_region;
   logic [RAM_AW-1:0]         err_addr;

   rom2ram_multi #(.REGIONS(REGIONS)) dut (
      .clk28(clk28), .rst(rst), .start(start),
      .region_en(region_en), .region_rom(region_rom),
      .region_ram(region_ram), .region_len(region_len),
      .rom_req(rom_req), .rom_addr(rom_addr),
      .rom_ack(rom_ack), .rom_data(rom_data),
      .ram_wren(ram_wren), .ram_rden(ram_rden),
      .ram_addr(ram_addr), .ram_dout(ram_dout),
      .ram_din(ram_din), .ram_grant(ram_grant),
      .busy(busy), .done(done), .error(error),
      .err_region(err_region), .err_addr(err_addr)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [RAM_AW-1:0] a;
      logic [7:0]        d;
   } wr_t;
   wr_t q[$];

   int rom_lat_mode = 2;
   bit grant_rand = 1'b0;
   int stall_n = 0;
   int caddr = -1;
   int cleft = 0;
   logic [7:0] mem [0:(1<<RAM_AW)-1];

   logic              cfg_en  [REGIONS];
   logic [ROM_AW-1:0] cfg_rom [REGIONS];
   logic [RAM_AW-1:0] cfg_ram [REGIONS];
   logic [LEN_W-1:0]  cfg_len [REGIONS];

   bit                exp_err;
   logic [RAM_AW-1:0] exp_eaddr;
   int                exp_ereg;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk28);
      #1;
   endtask

   task automatic apply_cfg();
      for (int i = 0; i < REGIONS; i++) begin
         region_en[i] = cfg_en[i];
         region_rom[i*ROM_AW +: ROM_AW] = cfg_rom[i];
         region_ram[i*RAM_AW +: RAM_AW] = cfg_ram[i];
         region_len[i*LEN_W +: LEN_W] = cfg_len[i];
      end
   endtask

   // Reference: every enabled byte is written once, plus once more per
   // corrupted read-back, until the retry allowance runs out.
   task automatic build_expect(input int ca, input int cl);
      int a, tries;
      logic [7:0] d;
      wr_t e;
      exp_err = 1'b0;
      exp_eaddr = '0;
      exp_ereg = 0;
      for (int i = 0; i < REGIONS; i++) begin
         if (cfg_en[i] && cfg_len[i] != 0) begin
            for (int k = 0; k < int'(cfg_len[i]); k++) begin
               a = (int'(cfg_ram[i]) + k) % (1 << RAM_AW);
               d = 8'((int'(cfg_rom[i]) + OFF + k) % (1 << ROM_AW));
               tries = 0;
               while (1) begin
                  e.a = RAM_AW'(a);
                  e.d = d;
                  q.push_back(e);
                  tries++;
                  if (a == ca && cl > 0) begin
                     cl--;
                     if (tries <= RETRIES) continue;
                     exp_err = 1'b1;
                     exp_eaddr = RAM_AW'(a);
                     exp_ereg = i;
                     return;
                  end
                  break;
               end
            end
         end
      end
   endtask

   // Flash: ack after a latency counted in cycles of rom_req.
   initial begin
      int cnt, lat;
      cnt = 0;
      lat = 2;
      forever begin
         tick();
         if (rom_req) begin
            if (cnt >= lat) begin
               rom_ack = 1'b1;
               rom_data = rom_addr[7:0];
               cnt = 0;
               lat = (rom_lat_mode < 0) ? int'($urandom_range(0, 3))
                                        : rom_lat_mode;
            end else begin
               rom_ack = 1'b0;
               cnt++;
            end
         end else begin
            rom_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   // SRAM: optional forced stall, random grant, read corruption.
   initial begin
      forever begin
         tick();
         ram_grant = 1'b0;
         if (ram_wren || ram_rden) begin
            if (stall_n > 0) stall_n--;
            else ram_grant = grant_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (ram_grant && ram_wren) mem[ram_addr] = ram_dout;
            if (ram_grant && ram_rden) begin
               ram_din = mem[ram_addr];
               if (int'(ram_addr) == caddr && cleft > 0) begin
                  ram_din = ram_din ^ 8'hA5;
                  cleft--;
               end
            end
         end
      end
   end

   // Monitor: protocol checks and scoreboard pops on granted writes.
   initial begin
      bit pv, p_wr, p_rd, p_req, p_gnt, p_ack;
      logic [RAM_AW-1:0] p_ra;
      logic [7:0] p_do;
      logic [ROM_AW-1:0] p_fa;
      wr_t e;
      pv = 1'b0;
      forever begin
         @(negedge clk28);
         chk("excl", 64'({ram_wren && ram_rden,
                          rom_req && (ram_wren || ram_rden)}), 64'(0));
         if (pv && p_wr && !p_gnt)
            chk("stall_wr", 64'({ram_wren, ram_addr, ram_dout}),
                64'({1'b1, p_ra, p_do}));
         if (pv && p_rd && !p_gnt)
            chk("stall_rd", 64'({ram_rden, ram_addr}), 64'({1'b1, p_ra}));
         if (pv && p_req && !p_ack)
            chk("stall_rom", 64'({rom_req, rom_addr}), 64'({1'b1, p_fa}));
         if (done || error)
            chk("idle_quiet", 64'({rom_req, ram_wren, ram_rden}), 64'(0));
         if (ram_wren && ram_grant) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write got addr %0h want none",
                        ram_addr);
            end else begin
               e = q.pop_front();
               chk("wr_addr", 64'(ram_addr), 64'(e.a));
               chk("wr_data", 64'(ram_dout), 64'(e.d));
            end
         end
         p_wr = ram_wren;
         p_rd = ram_rden;
         p_req = rom_req;
         p_gnt = ram_grant;
         p_ack = rom_ack;
         p_ra = ram_addr;
         p_do = ram_dout;
         p_fa = rom_addr;
         pv = !rst;
      end
   end

   task automatic wait_end(input string nm);
      int n;
      n = 0;
      while (!(done || error) && n < 20000) begin
         tick();
         n++;
      end
      if (!(done || error)) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout got busy=%0b want done or error",
                  nm, busy);
      end
   endtask

   task automatic finish_check(input string nm);
      chk({nm, "_done"}, 64'(done), 64'(!exp_err));
      chk({nm, "_error"}, 64'(error), 64'(exp_err));
      chk({nm, "_busy"}, 64'(busy), 64'(0));
      if (exp_err) begin
         chk({nm, "_eaddr"}, 64'(err_addr), 64'(exp_eaddr));
         chk({nm, "_ereg"}, 64'(err_region), 64'(exp_ereg));
      end
      chk({nm, "_qleft"}, 64'(q.size()), 64'(0));
      q.delete();
   endtask

   task automatic run(input string nm, input int ca, input int cl);
      apply_cfg();
      build_expect(ca, cl);
      caddr = ca;
      cleft = cl;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, "_busy_on"}, 64'(busy), 64'(1));
      wait_end(nm);
      finish_check(nm);
   endtask

   task automatic all_zero(input string nm);
      chk(nm, 64'({rom_req, ram_wren, ram_rden, busy, done, error,
                   err_region, rom_addr, ram_addr, ram_dout}), 64'(0));
      chk({nm, "_eaddr"}, 64'(err_addr), 64'(0));
   endtask

   initial begin
      int n;
      // Auto-start copy of region 0 straight out of reset.
      cfg_en[0] = 1'b1; cfg_rom[0] = '0; cfg_ram[0] = '0; cfg_len[0] = 4;
      cfg_en[1] = 1'b0; cfg_rom[1] = 24'h123;
      cfg_ram[1] = 19'h100; cfg_len[1] = 5;
      apply_cfg();
      repeat (3) tick();
      all_zero("reset_outs");
      build_expect(-1, 0);
      rst = 1'b0;
      tick();
      chk("auto_busy", 64'(busy), 64'(1));
      wait_end("t1");
      finish_check("t1");
      chk("t1_mem", 64'({mem[0], mem[1], mem[2], mem[3]}),
          64'(32'h5657_5859));

      // Zero-length region skipped, destination wraps at top of SRAM.
      cfg_en[0] = 1'b1; cfg_len[0] = 0;
      cfg_en[1] = 1'b1; cfg_rom[1] = 24'h10;
      cfg_ram[1] = 19'h7FFFE; cfg_len[1] = 3;
      run("wrap", -1, 0);
      chk("wrap_mem", 64'({mem[19'h7FFFE], mem[19'h7FFFF], mem[0]}),
          64'(24'h666768));

      // Ten-cycle write stall.
      cfg_en[1] = 1'b0;
      cfg_rom[0] = 24'h200; cfg_ram[0] = 19'h1234; cfg_len[0] = 2;
      stall_n = 10;
      run("stall", -1, 0);
      chk("stall_used", 64'(stall_n), 64'(0));

      // Two corrupted read-backs recover on the third write.
      cfg_rom[0] = '0; cfg_ram[0] = '0; cfg_len[0] = 4;
      run("retry", 2, 2);
      chk("retry_used", 64'(cleft), 64'(0));

      // Permanent corruption ends in ERROR.
      run("perm", 2, 100);
      repeat (20) tick();
      chk("perm_hold", 64'({error, done, busy}), 64'(3'b100));

      // Randomised regions, latencies, grants and corruption.
      rom_lat_mode = -1;
      grant_rand = 1'b1;
      for (int t = 0; t < 8; t++) begin
         int rr;
         for (int i = 0; i < REGIONS; i++) begin
            cfg_en[i] = 1'($urandom_range(0, 3) != 0);
            cfg_len[i] = LEN_W'($urandom_range(0, 6));
            cfg_rom[i] = ROM_AW'($urandom);
            cfg_ram[i] = $urandom_range(0, 1) ? RAM_AW'(19'h7FFFC)
                                              : RAM_AW'($urandom);
         end
         rr = $urandom_range(0, REGIONS - 1);
         run("rand",
             (int'(cfg_ram[rr]) + int'($urandom_range(0, 3))) % (1 << RAM_AW),
             int'($urandom_range(0, 3)));
      end

      // Reset during ROM_REQ, auto restart, start ignored while busy.
      cfg_en[0] = 1'b1; cfg_rom[0] = 24'h40; cfg_ram[0] = 19'h300;
      cfg_len[0] = 3;
      cfg_en[1] = 1'b1; cfg_rom[1] = 24'h80; cfg_ram[1] = 19'h400;
      cfg_len[1] = 2;
      apply_cfg();
      build_expect(-1, 0);
      caddr = -1;
      cleft = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!rom_req && n < 100) begin
         tick();
         n++;
      end
      chk("rst_saw_req", 64'(rom_req), 64'(1));
      rst = 1'b1;
      tick();
      all_zero("rst_mid");
      q.delete();
      build_expect(-1, 0);
      rst = 1'b0;
      tick();
      chk("rst_auto_busy", 64'(busy), 64'(1));
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_end("rst");
      finish_check("rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
